// File: rtl/stack_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// stack_ptr_ctrl
//
// Stack-pointer controller for the multicycle datapath. It owns SP and turns
// PUSH/POP/CALL/RET/LOADSP/PUSHM/POPM commands into stack memory addresses and
// read/write strobes. The stack grows downward from STACK_BASE (empty) towards
// STACK_LIMIT (full). Every command is bounds-checked when it is accepted. An
// illegal command is rejected as a whole and sets a sticky fault flag.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   op_valid   in   command present
//   op_ready   out  controller idle and able to accept a command
//   op_code    in   000 NOP 001 PUSH 010 POP 011 CALL 100 RET
//                   101 LOADSP 110 PUSHM 111 POPM
//   op_count   in   word count for PUSHM/POPM
//   op_data    in   new SP value for LOADSP
//   fault_clr  in   clears the sticky fault flags
//   sp         out  current stack pointer
//   mem_addr   out  stack memory address of the current beat
//   mem_we     out  write strobe (push-class beat)
//   mem_re     out  read strobe (pop-class beat)
//   done       out  one-cycle pulse when a command completes or is rejected
//   err_ovf    out  sticky push-beyond-limit fault
//   err_unf    out  sticky pop-beyond-base fault
//   err_range  out  sticky LOADSP-out-of-window fault
//   empty      out  sp == STACK_BASE
//   full       out  sp < STACK_LIMIT + STEP
// -----------------------------------------------------------------------------
module stack_ptr_ctrl #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] STACK_BASE  = 32'h0000_0400,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = 32'h0000_0300,
    parameter int                STEP        = 1,
    parameter int                CNT_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op_code,
    input  logic [CNT_W-1:0]  op_count,
    input  logic [ADDR_W-1:0] op_data,
    input  logic              fault_clr,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic              done,
    output logic              err_ovf,
    output logic              err_unf,
    output logic              err_range,
    output logic              empty,
    output logic              full
);

    // Wide enough that sp +/- n*STEP never wraps.
    localparam int W = ADDR_W + CNT_W + 1;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_PUSH   = 3'b001;
    localparam logic [2:0] OP_POP    = 3'b010;
    localparam logic [2:0] OP_CALL   = 3'b011;
    localparam logic [2:0] OP_RET    = 3'b100;
    localparam logic [2:0] OP_LOADSP = 3'b101;
    localparam logic [2:0] OP_PUSHM  = 3'b110;
    localparam logic [2:0] OP_POPM   = 3'b111;

    localparam logic [ADDR_W-1:0] STEP_A   = ADDR_W'(STEP);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
    localparam logic [W-1:0]      BASE_W   = W'(STACK_BASE);
    localparam logic [W-1:0]      LIMIT_W  = W'(STACK_LIMIT);
    localparam logic [W-1:0]      STEP_W   = W'(STEP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_FIN   = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] sp_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic              mem_re_q;
    logic              done_q;
    logic              dir_push_q;
    logic [CNT_W-1:0]  beats_q;      // beats still to issue after the current one
    logic              err_ovf_q;
    logic              err_unf_q;
    logic              err_range_q;

    logic              accept_s;
    logic              is_push_s;
    logic              is_pop_s;
    logic [CNT_W-1:0]  n_s;
    logic [W-1:0]      n_step_s;
    logic              push_ok_s;
    logic              pop_ok_s;
    logic              load_ok_s;
    logic              set_ovf_s;
    logic              set_unf_s;
    logic              set_range_s;

    // Command decode and acceptance-time bounds checks.
    always_comb begin
        accept_s  = op_valid && (state_q == S_IDLE);
        is_push_s = (op_code == OP_PUSH) || (op_code == OP_CALL) || (op_code == OP_PUSHM);
        is_pop_s  = (op_code == OP_POP)  || (op_code == OP_RET)  || (op_code == OP_POPM);
        if ((op_code == OP_PUSHM) || (op_code == OP_POPM)) begin
            n_s = op_count;
        end else begin
            n_s = CNT_ONE;
        end
        n_step_s  = W'(n_s) * STEP_W;
        // sp - n*STEP >= LIMIT rewritten as an addition so it cannot underflow.
        push_ok_s = (W'(sp_q) >= (LIMIT_W + n_step_s));
        pop_ok_s  = ((W'(sp_q) + n_step_s) <= BASE_W);
        load_ok_s = (op_data >= STACK_LIMIT) && (op_data <= STACK_BASE);
        set_ovf_s   = accept_s && is_push_s && !push_ok_s;
        set_unf_s   = accept_s && is_pop_s  && !pop_ok_s;
        set_range_s = accept_s && (op_code == OP_LOADSP) && !load_ok_s;
    end

    // Control FSM with SP, address, strobe and done registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            sp_q       <= STACK_BASE;
            mem_addr_q <= {ADDR_W{1'b0}};
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b0;
            done_q     <= 1'b0;
            dir_push_q <= 1'b0;
            beats_q    <= CNT_ZERO;
        end else begin
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        if (is_push_s && push_ok_s && (n_s != CNT_ZERO)) begin
                            mem_we_q   <= 1'b1;
                            mem_addr_q <= sp_q - STEP_A;
                            sp_q       <= sp_q - STEP_A;
                            dir_push_q <= 1'b1;
                            beats_q    <= n_s - CNT_ONE;
                            done_q     <= (n_s == CNT_ONE);
                            state_q    <= S_BURST;
                        end else if (is_pop_s && pop_ok_s && (n_s != CNT_ZERO)) begin
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= sp_q;
                            sp_q       <= sp_q + STEP_A;
                            dir_push_q <= 1'b0;
                            beats_q    <= n_s - CNT_ONE;
                            done_q     <= (n_s == CNT_ONE);
                            state_q    <= S_BURST;
                        end else begin
                            // NOP, LOADSP, zero-length bursts and rejected commands.
                            if ((op_code == OP_LOADSP) && load_ok_s) begin
                                sp_q <= op_data;
                            end else begin
                                sp_q <= sp_q;
                            end
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_BURST: begin
                    if (beats_q != CNT_ZERO) begin
                        if (dir_push_q) begin
                            mem_we_q   <= 1'b1;
                            mem_addr_q <= sp_q - STEP_A;
                            sp_q       <= sp_q - STEP_A;
                        end else begin
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= sp_q;
                            sp_q       <= sp_q + STEP_A;
                        end
                        beats_q <= beats_q - CNT_ONE;
                        done_q  <= (beats_q == CNT_ONE);
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky faults: a new fault wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
            err_range_q <= 1'b0;
        end else begin
            err_ovf_q   <= set_ovf_s   || (err_ovf_q   && !fault_clr);
            err_unf_q   <= set_unf_s   || (err_unf_q   && !fault_clr);
            err_range_q <= set_range_s || (err_range_q && !fault_clr);
        end
    end

    assign op_ready  = (state_q == S_IDLE);
    assign sp        = sp_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign done      = done_q;
    assign err_ovf   = err_ovf_q;
    assign err_unf   = err_unf_q;
    assign err_range = err_range_q;
    assign empty     = (sp_q == STACK_BASE);
    assign full      = (sp_q < (STACK_LIMIT + STEP_A));

endmodule

// File: tb/tb_stack_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stack_ptr_ctrl
//
// Directed self-checking bench for stack_ptr_ctrl with default parameters
// (base 0x400, limit 0x300, step 1). Inputs change on the falling edge and
// outputs are sampled on the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_stack_ptr_ctrl;

    localparam logic [2:0] NOP    = 3'b000;
    localparam logic [2:0] PUSH   = 3'b001;
    localparam logic [2:0] POP    = 3'b010;
    localparam logic [2:0] CALL   = 3'b011;
    localparam logic [2:0] RET    = 3'b100;
    localparam logic [2:0] LOADSP = 3'b101;
    localparam logic [2:0] PUSHM  = 3'b110;
    localparam logic [2:0] POPM   = 3'b111;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_code;
    logic [3:0]  op_count;
    logic [31:0] op_data;
    logic        fault_clr;
    logic [31:0] sp;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic        mem_re;
    logic        done;
    logic        err_ovf;
    logic        err_unf;
    logic        err_range;
    logic        empty;
    logic        full;

    int n_cmp = 0;
    int n_mis = 0;

    stack_ptr_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .op_count  (op_count),
        .op_data   (op_data),
        .fault_clr (fault_clr),
        .sp        (sp),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .done      (done),
        .err_ovf   (err_ovf),
        .err_unf   (err_unf),
        .err_range (err_range),
        .empty     (empty),
        .full      (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge; returns at the falling edge of the first
    // cycle after acceptance (op_valid already dropped).
    task automatic send(input logic [2:0] code, input logic [3:0] cnt, input logic [31:0] data);
        int waited = 0;
        while (op_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (op_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL send_ready: op_ready got %b expected 1", op_ready);
        end
        op_valid = 1'b1;
        op_code  = code;
        op_count = cnt;
        op_data  = data;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        op_code  = NOP;
        op_count = 4'd0;
    endtask

    task automatic test_reset();
        rst = 1'b0; op_valid = 1'b0; op_code = NOP; op_count = 4'd0;
        op_data = 32'd0; fault_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (sp !== 32'h400) begin n_mis++; $display("FAIL reset_sp: got %h expected 00000400", sp); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_mis++; $display("FAIL reset_addr: got %h expected 00000000", mem_addr); end
        n_cmp++; if ({mem_we, mem_re, done} !== 3'b000) begin n_mis++; $display("FAIL reset_strobes: we/re/done got %b expected 000", {mem_we, mem_re, done}); end
        n_cmp++; if ({err_ovf, err_unf, err_range} !== 3'b000) begin n_mis++; $display("FAIL reset_errs: got %b expected 000", {err_ovf, err_unf, err_range}); end
        n_cmp++; if ({op_ready, empty, full} !== 3'b110) begin n_mis++; $display("FAIL reset_flags: ready/empty/full got %b expected 110", {op_ready, empty, full}); end
    endtask

    task automatic test_push3();
        logic [31:0] exp_sp;
        for (int i = 1; i <= 3; i++) begin
            exp_sp = 32'h400 - 32'(i);
            send(PUSH, 4'd0, 32'd0);
            n_cmp++; if (sp !== exp_sp) begin n_mis++; $display("FAIL push3_sp[%0d]: got %h expected %h", i, sp, exp_sp); end
            n_cmp++; if (mem_addr !== exp_sp) begin n_mis++; $display("FAIL push3_addr[%0d]: got %h expected %h", i, mem_addr, exp_sp); end
            n_cmp++; if ({mem_we, mem_re, done, op_ready} !== 4'b1010) begin n_mis++; $display("FAIL push3_beat[%0d]: we/re/done/ready got %b expected 1010", i, {mem_we, mem_re, done, op_ready}); end
            @(negedge clk);
            n_cmp++; if ({mem_we, mem_re, done, op_ready} !== 4'b0001) begin n_mis++; $display("FAIL push3_after[%0d]: we/re/done/ready got %b expected 0001", i, {mem_we, mem_re, done, op_ready}); end
        end
    endtask

    task automatic test_loadsp_ok(input logic [31:0] val);
        send(LOADSP, 4'd0, val);
        n_cmp++; if (sp !== val) begin n_mis++; $display("FAIL loadsp_sp: got %h expected %h", sp, val); end
        n_cmp++; if ({mem_we, mem_re, done, err_range} !== 4'b0010) begin n_mis++; $display("FAIL loadsp_flags: we/re/done/range got %b expected 0010", {mem_we, mem_re, done, err_range}); end
        @(negedge clk);
    endtask

    task automatic test_pushm();
        logic [31:0] exp_sp;
        send(PUSHM, 4'd4, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            exp_sp = 32'h400 - 32'(i);
            n_cmp++; if ({mem_we, mem_re, op_ready} !== 3'b100) begin n_mis++; $display("FAIL pushm_beat[%0d]: we/re/ready got %b expected 100", i, {mem_we, mem_re, op_ready}); end
            n_cmp++; if (mem_addr !== exp_sp || sp !== exp_sp) begin n_mis++; $display("FAIL pushm_addr[%0d]: addr %h sp %h expected %h", i, mem_addr, sp, exp_sp); end
            n_cmp++; if (done !== (i == 4)) begin n_mis++; $display("FAIL pushm_done[%0d]: got %b expected %b", i, done, (i == 4)); end
            @(negedge clk);
        end
        n_cmp++; if ({mem_we, done, op_ready} !== 3'b001 || sp !== 32'h3FC) begin n_mis++; $display("FAIL pushm_end: we/done/ready %b sp %h expected 001 000003fc", {mem_we, done, op_ready}, sp); end
    endtask

    task automatic test_popm();
        logic [31:0] exp_addr;
        send(POPM, 4'd3, 32'd0);
        for (int i = 0; i < 3; i++) begin
            exp_addr = 32'h3FC + 32'(i);
            n_cmp++; if ({mem_we, mem_re, op_ready} !== 3'b010) begin n_mis++; $display("FAIL popm_beat[%0d]: we/re/ready got %b expected 010", i, {mem_we, mem_re, op_ready}); end
            n_cmp++; if (mem_addr !== exp_addr || sp !== exp_addr + 32'd1) begin n_mis++; $display("FAIL popm_addr[%0d]: addr %h sp %h expected addr %h", i, mem_addr, sp, exp_addr); end
            n_cmp++; if (done !== (i == 2)) begin n_mis++; $display("FAIL popm_done[%0d]: got %b expected %b", i, done, (i == 2)); end
            @(negedge clk);
        end
        n_cmp++; if (sp !== 32'h3FF || mem_re !== 1'b0) begin n_mis++; $display("FAIL popm_end: sp %h re %b expected 000003ff 0", sp, mem_re); end
        // POPM 5 from 0x3FD would end at 0x402: rejected whole.
        test_loadsp_ok(32'h3FD);
        send(POPM, 4'd5, 32'd0);
        n_cmp++; if ({mem_we, mem_re, done, err_unf} !== 4'b0011) begin n_mis++; $display("FAIL popm_rej: we/re/done/unf got %b expected 0011", {mem_we, mem_re, done, err_unf}); end
        n_cmp++; if (sp !== 32'h3FD) begin n_mis++; $display("FAIL popm_rej_sp: got %h expected 000003fd", sp); end
        @(negedge clk);
        n_cmp++; if ({mem_re, done, op_ready} !== 3'b001) begin n_mis++; $display("FAIL popm_rej_after: re/done/ready got %b expected 001", {mem_re, done, op_ready}); end
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        n_cmp++; if (err_unf !== 1'b0) begin n_mis++; $display("FAIL popm_clr: err_unf got %b expected 0", err_unf); end
    endtask

    task automatic test_underflow();
        test_loadsp_ok(32'h400);
        send(POP, 4'd0, 32'd0);
        n_cmp++; if ({mem_re, mem_we, done, err_unf} !== 4'b0011) begin n_mis++; $display("FAIL unf_pop: re/we/done/unf got %b expected 0011", {mem_re, mem_we, done, err_unf}); end
        n_cmp++; if (sp !== 32'h400 || empty !== 1'b1) begin n_mis++; $display("FAIL unf_sp: sp %h empty %b expected 00000400 1", sp, empty); end
        @(negedge clk);
        n_cmp++; if (err_unf !== 1'b1) begin n_mis++; $display("FAIL unf_sticky: got %b expected 1", err_unf); end
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        n_cmp++; if (err_unf !== 1'b0) begin n_mis++; $display("FAIL unf_clr: got %b expected 0", err_unf); end
    endtask

    task automatic test_overflow_range();
        test_loadsp_ok(32'h300);
        n_cmp++; if (full !== 1'b1 || empty !== 1'b0) begin n_mis++; $display("FAIL ovf_full: full %b empty %b expected 1 0", full, empty); end
        send(PUSH, 4'd0, 32'd0);
        n_cmp++; if ({mem_we, mem_re, done, err_ovf} !== 4'b0011 || sp !== 32'h300) begin n_mis++; $display("FAIL ovf_push: we/re/done/ovf %b sp %h expected 0011 00000300", {mem_we, mem_re, done, err_ovf}, sp); end
        @(negedge clk);
        send(LOADSP, 4'd0, 32'h500);
        n_cmp++; if ({done, err_range} !== 2'b11 || sp !== 32'h300) begin n_mis++; $display("FAIL range_hi: done/range %b sp %h expected 11 00000300", {done, err_range}, sp); end
        @(negedge clk);
        // Set wins over clear: a rejected PUSH in the same cycle as fault_clr
        // keeps err_ovf, while err_range (not re-set) clears.
        fault_clr = 1'b1;
        send(PUSH, 4'd0, 32'd0);
        fault_clr = 1'b0;
        n_cmp++; if ({err_ovf, err_range} !== 2'b10) begin n_mis++; $display("FAIL set_wins: ovf/range got %b expected 10", {err_ovf, err_range}); end
        @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        send(LOADSP, 4'd0, 32'h2FF);
        n_cmp++; if ({err_range, err_ovf} !== 2'b10 || sp !== 32'h300) begin n_mis++; $display("FAIL range_lo: range/ovf %b sp %h expected 10 00000300", {err_range, err_ovf}, sp); end
        @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
    endtask

    task automatic test_misc_ops();
        test_loadsp_ok(32'h380);
        send(CALL, 4'd0, 32'd0);
        n_cmp++; if ({mem_we, mem_re, done} !== 3'b101 || mem_addr !== 32'h37F || sp !== 32'h37F) begin n_mis++; $display("FAIL call: we/re/done %b addr %h sp %h expected 101 0000037f 0000037f", {mem_we, mem_re, done}, mem_addr, sp); end
        @(negedge clk);
        send(RET, 4'd0, 32'd0);
        n_cmp++; if ({mem_we, mem_re, done} !== 3'b011 || mem_addr !== 32'h37F || sp !== 32'h380) begin n_mis++; $display("FAIL ret: we/re/done %b addr %h sp %h expected 011 0000037f 00000380", {mem_we, mem_re, done}, mem_addr, sp); end
        @(negedge clk);
        send(PUSHM, 4'd0, 32'd0);
        n_cmp++; if ({mem_we, mem_re, done} !== 3'b001 || sp !== 32'h380) begin n_mis++; $display("FAIL pushm0: we/re/done %b sp %h expected 001 00000380", {mem_we, mem_re, done}, sp); end
        @(negedge clk);
        send(NOP, 4'd0, 32'd0);
        n_cmp++; if ({mem_we, mem_re, done} !== 3'b001 || sp !== 32'h380) begin n_mis++; $display("FAIL nop: we/re/done %b sp %h expected 001 00000380", {mem_we, mem_re, done}, sp); end
        @(negedge clk);
        n_cmp++; if ({err_ovf, err_unf, err_range, done} !== 4'b0000) begin n_mis++; $display("FAIL misc_errs: ovf/unf/range/done got %b expected 0000", {err_ovf, err_unf, err_range, done}); end
    endtask

    task automatic test_reset_mid_burst();
        test_loadsp_ok(32'h400);
        send(PUSHM, 4'd6, 32'd0);
        @(negedge clk);
        n_cmp++; if (mem_we !== 1'b1 || sp !== 32'h3FE) begin n_mis++; $display("FAIL rmb_beat2: we %b sp %h expected 1 000003fe", mem_we, sp); end
        rst = 1'b0;
        #1;
        n_cmp++; if ({mem_we, mem_re, done} !== 3'b000 || sp !== 32'h400 || mem_addr !== 32'h0) begin n_mis++; $display("FAIL rmb_async: we/re/done %b sp %h addr %h expected 000 00000400 00000000", {mem_we, mem_re, done}, sp, mem_addr); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (mem_we !== 1'b0 || op_ready !== 1'b1 || sp !== 32'h400) begin n_mis++; $display("FAIL rmb_after[%0d]: we %b ready %b sp %h expected 0 1 00000400", i, mem_we, op_ready, sp); end
        end
    endtask

    initial begin
        test_reset();
        test_push3();
        test_loadsp_ok(32'h400);
        test_pushm();
        test_popm();
        test_underflow();
        test_overflow_range();
        test_misc_ops();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/stack_ptr_ctrl.md
Name: stack_ptr_ctrl

Overview:
- Parametrised stack-pointer controller for the multicycle datapath. It owns SP and generates stack memory addresses and strobes for PUSH/POP/CALL/RET, plus LOADSP and multi-word PUSHM/POPM bursts.
- Adds bounds checking against a configurable stack window, with sticky overflow/underflow/range faults.
- Uses a valid/ready command handshake, so the main control FSM stalls while a burst is in progress.

Parameters:
- ADDR_W, 32, width of SP and memory address.
- STACK_BASE, 32'h0000_0400, empty-stack SP value (stack grows downward).
- STACK_LIMIT, 32'h0000_0300, lowest legal SP value (full-stack SP).
- STEP, 1, address decrement/increment per word.
- CNT_W, 4, width of the burst word count.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- op_valid  input  1  command present
- op_ready  output  1  controller can accept a command
- op_code  input  3  000 NOP, 001 PUSH, 010 POP, 011 CALL, 100 RET, 101 LOADSP, 110 PUSHM, 111 POPM
- op_count  input  CNT_W  word count for PUSHM/POPM
- op_data  input  ADDR_W  new SP value for LOADSP
- fault_clr  input  1  clears sticky fault flags
- sp  output  ADDR_W  current stack pointer
- mem_addr  output  ADDR_W  stack memory address for the current access
- mem_we  output  1  write strobe (PUSH/CALL/PUSHM beat)
- mem_re  output  1  read strobe (POP/RET/POPM beat)
- done  output  1  one-cycle pulse when a command completes or is rejected
- err_ovf  output  1  sticky: push beyond STACK_LIMIT attempted
- err_unf  output  1  sticky: pop beyond STACK_BASE attempted
- err_range  output  1  sticky: LOADSP value outside [STACK_LIMIT, STACK_BASE]
- empty  output  1  sp == STACK_BASE (combinational)
- full  output  1  sp < STACK_LIMIT + STEP (combinational)

Behaviour:
- Reset (rst low, asynchronous): state IDLE, sp = STACK_BASE, mem_addr = 0, mem_we = mem_re = done = 0, all err flags 0, beat counter 0.
- FSM states: IDLE, BURST, FIN.
  - op_ready = 1 only in IDLE.
  - A command is accepted on a rising edge with op_valid & op_ready.
- Bounds check at acceptance, with n = 1 for PUSH/POP/CALL/RET and n = op_count for PUSHM/POPM:
  - Push-class is legal iff sp - n*STEP >= STACK_LIMIT.
  - Pop-class is legal iff sp + n*STEP <= STACK_BASE.
  - Arithmetic is done at ADDR_W+CNT_W+1 bits, so there is no wrap-around.
- Illegal command: no strobes and no SP change. Set err_ovf or err_unf, and pulse done in the next cycle (FIN). No partial bursts.
- Single push (PUSH, CALL), in the cycle after acceptance: mem_addr = sp-STEP, mem_we = 1, sp <= sp-STEP, done = 1. Latency is 1.
- Single pop (POP, RET), in the cycle after acceptance: mem_addr = old sp, mem_re = 1, sp <= sp+STEP, done = 1.
- CALL and RET use identical SP/strobe timing to PUSH and POP. PC handling is outside this block.
- PUSHM/POPM with n > 0:
  - Enter BURST and issue one beat per cycle for n cycles, with addresses as for single ops and SP updated every beat.
  - done is asserted with the last beat, then return to IDLE.
  - op_count is captured at acceptance.
- PUSHM/POPM with n = 0: no strobes, done pulses the next cycle.
- LOADSP:
  - If STACK_LIMIT <= op_data <= STACK_BASE: sp <= op_data next cycle, done = 1.
  - Otherwise: sp unchanged, err_range set, done = 1.
- NOP: accepted, done pulses next cycle, no other effect.
- mem_we and mem_re are never asserted together, and are 0 outside the beat cycle.
- Sticky errors: a flag is set on its fault and cleared by fault_clr. If a set and fault_clr occur in the same cycle, set wins. Faults do not block subsequent commands.
- Async reset mid-burst: abort immediately, no further strobes, sp = STACK_BASE.

Test Plan:
- Reset, then PUSH x3 -> sp 0x3FF, 0x3FE, 0x3FD; mem_addr matches the new sp; mem_we pulses 1 cycle each; done each cycle after acceptance.
- PUSHM count=4 from sp=0x400 -> 4 consecutive mem_we beats at 0x3FF..0x3FC; op_ready low for 4 cycles; done on beat 4; final sp 0x3FC.
- POP at sp=0x400 -> err_unf=1, no mem_re, sp stays 0x400, done pulses; fault_clr -> err_unf=0.
- LOADSP 0x300 then PUSH -> err_ovf=1, sp 0x300. LOADSP 0x500 -> err_range=1, sp unchanged.
- POPM count=3 from sp=0x3FC -> mem_re at 0x3FC, 0x3FD, 0x3FE; sp 0x3FF. POPM count=5 from 0x3FD -> rejected whole, err_unf, no strobes.
- Drive rst low during beat 2 of PUSHM count=6 -> outputs go to reset values immediately, sp=0x400, no further mem_we.
